// File: rtl/adc_scan_sched.sv
// adc_scan_sched
//   Sequences ADC conversions over a channel mask. A scan walks the pending
//   channels lowest index first, issuing one transfer request per channel and
//   forwarding each result. Scans run once (start) or repeatedly (scan_en),
//   with a programmable idle gap between repeated scans. A transfer that does
//   not complete within TIMEOUT wait cycles is abandoned and flagged.
//
// Ports
//   clk, n_rst          clock, asynchronous active-low reset
//   start               single-scan request pulse (honoured in IDLE only)
//   scan_en             continuous-scan enable
//   chan_mask           channels to convert, sampled when a scan begins
//   scan_gap            idle cycles between continuous scans (0 acts as 1)
//   err_clr             clears timeout_err
//   xfer_start          one-cycle conversion request to the transfer engine
//   xfer_chansel        channel index for the current transfer
//   xfer_done/xfer_data transfer-complete strobe and its result
//   res_valid           one-cycle result strobe
//   res_chan/res_data   result channel/data, held between strobes
//   scan_done           one-cycle end-of-scan strobe
//   busy                high whenever a scan or gap is in progress
//   timeout_err         sticky transfer-timeout flag

module adc_scan_sched #(
  parameter int ADC_WIDTH    = 12,
  parameter int NUM_CHANNELS = 8,
  parameter int TIMEOUT      = 64
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic                    scan_en,
  input  logic [NUM_CHANNELS-1:0] chan_mask,
  input  logic [15:0]             scan_gap,
  input  logic                    err_clr,
  output logic                    xfer_start,
  output logic [4:0]              xfer_chansel,
  input  logic                    xfer_done,
  input  logic [ADC_WIDTH-1:0]    xfer_data,
  output logic                    res_valid,
  output logic [4:0]              res_chan,
  output logic [ADC_WIDTH-1:0]    res_data,
  output logic                    scan_done,
  output logic                    busy,
  output logic                    timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  // Last WAIT cycle index (counter is zero-based).
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t                  state;
  state_t                  state_next;
  logic [NUM_CHANNELS-1:0] pending;
  logic [NUM_CHANNELS-1:0] low_bit;
  logic [4:0]              low_idx;
  logic [15:0]             wait_cnt;
  logic [15:0]             gap_cnt;
  logic [15:0]             gap_last;
  logic                    done_hit;
  logic                    timeout_hit;
  logic                    gap_end;
  logic                    mask_any;

  // Isolate the lowest set bit of the pending mask (two's-complement trick).
  assign low_bit = pending & (~pending + NUM_CHANNELS'(1));

  // Index of the lowest pending channel; descending scan so the lowest wins.
  always_comb begin
    low_idx = 5'd0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = i[4:0];
    end
  end

  assign mask_any    = |chan_mask;
  assign done_hit    = (state == S_WAIT) && xfer_done;
  // A completion on the final WAIT cycle still counts as a completion.
  assign timeout_hit = (state == S_WAIT) && !xfer_done && (wait_cnt == WAIT_LAST);
  // A zero gap behaves as a single gap cycle.
  assign gap_last    = (scan_gap == 16'd0) ? 16'd0 : scan_gap - 16'd1;
  assign gap_end     = (gap_cnt >= gap_last);

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if ((start || scan_en) && mask_any) state_next = S_SELECT;
      S_SELECT: begin
        if (|pending)     state_next = S_START;
        else if (scan_en) state_next = S_GAP;
        else              state_next = S_IDLE;
      end
      S_START:  state_next = S_WAIT;
      S_WAIT:   if (done_hit || timeout_hit) state_next = S_SELECT;
      S_GAP: begin
        if (!scan_en)     state_next = S_IDLE;
        else if (gap_end) state_next = mask_any ? S_SELECT : S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    xfer_start = 1'b0;
    scan_done  = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE:   busy       = 1'b0;
      S_SELECT: scan_done  = ~|pending;
      S_START:  xfer_start = 1'b1;
      default:  ;
    endcase
  end

  // Datapath: pending mask, channel select, counters and result registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pending      <= '0;
      xfer_chansel <= 5'd0;
      wait_cnt     <= 16'd0;
      gap_cnt      <= 16'd0;
      res_valid    <= 1'b0;
      res_chan     <= 5'd0;
      res_data     <= '0;
      timeout_err  <= 1'b0;
    end else begin
      // The mask is only sampled when a scan begins, so mid-scan mask
      // changes cannot disturb the channels still pending.
      if ((state == S_IDLE || state == S_GAP) && state_next == S_SELECT) begin
        pending <= chan_mask;
      end else if (state == S_SELECT && |pending) begin
        pending      <= pending & ~low_bit;
        xfer_chansel <= low_idx;
      end

      if (state == S_START)     wait_cnt <= 16'd0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + 16'd1;

      if (state == S_GAP) gap_cnt <= gap_cnt + 16'd1;
      else                gap_cnt <= 16'd0;

      res_valid <= done_hit;
      if (done_hit) begin
        res_data <= xfer_data;
        res_chan <= xfer_chansel;
      end

      // A timeout wins over a simultaneous clear.
      if (timeout_hit)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_scan_sched.sv
// Self-checking bench for adc_scan_sched: a transfer-engine model answers
// requests, expected channel selections and results are queued by the
// stimulus, and a monitor pops and compares them as the DUT produces them.

module tb_adc_scan_sched;
  localparam int AW = 12;
  localparam int NC = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic          start = 1'b0;
  logic          scan_en = 1'b0;
  logic [NC-1:0] chan_mask = '0;
  logic [15:0]   scan_gap = 16'd0;
  logic          err_clr = 1'b0;
  logic          xfer_start;
  logic [4:0]    xfer_chansel;
  logic          xfer_done;
  logic [AW-1:0] xfer_data;
  logic          res_valid;
  logic [4:0]    res_chan;
  logic [AW-1:0] res_data;
  logic          scan_done;
  logic          busy;
  logic          timeout_err;

  logic          eng_done = 1'b0;
  logic          force_done = 1'b0;
  logic          engine_on = 1'b0;
  logic [AW-1:0] eng_data = '0;
  logic [4:0]    eng_ch = 5'd0;
  int            eng_cd = 0;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int cyc = 0;
  int s0 = 0;

  logic [4:0]  exp_sel[$];
  logic [16:0] exp_res[$];

  assign xfer_done = eng_done | force_done;
  assign xfer_data = eng_data;

  adc_scan_sched #(.ADC_WIDTH(AW), .NUM_CHANNELS(NC), .TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .scan_en(scan_en),
    .chan_mask(chan_mask), .scan_gap(scan_gap), .err_clr(err_clr),
    .xfer_start(xfer_start), .xfer_chansel(xfer_chansel),
    .xfer_done(xfer_done), .xfer_data(xfer_data),
    .res_valid(res_valid), .res_chan(res_chan), .res_data(res_data),
    .scan_done(scan_done), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Transfer engine: done strobe with data 0x0A5+ch, five cycles after request.
  always @(negedge clk) begin
    eng_done = 1'b0;
    if (!n_rst) begin
      eng_cd = 0;
    end else begin
      if (eng_cd > 0) begin
        eng_cd--;
        if (eng_cd == 0) begin
          eng_done = 1'b1;
          eng_data = 12'h0A5 + AW'(eng_ch);
        end
      end
      if (engine_on && xfer_start) begin
        eng_cd = 5;
        eng_ch = xfer_chansel;
      end
    end
  end

  // Monitor: compares every request and result against the queues.
  always @(negedge clk) begin : monitor
    logic [4:0]  es;
    logic [16:0] er;
    if (n_rst) begin
      if (xfer_start) begin
        if (exp_sel.size() == 0) check("unexpected_xfer_start", 32'(xfer_start), 32'd0);
        else begin
          es = exp_sel.pop_front();
          check("xfer_chansel", 32'(xfer_chansel), 32'(es));
        end
      end
      if (res_valid) begin
        if (exp_res.size() == 0) check("unexpected_res_valid", 32'(res_valid), 32'd0);
        else begin
          er = exp_res.pop_front();
          check("res_chan_data", 32'({res_chan, res_data}), 32'(er));
        end
      end
      if (scan_done) done_cnt++;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_xfer_start(input int maxc);
    logic seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (xfer_start) seen = 1'b1;
    end
    check("wait_xfer_start", 32'(seen), 32'd1);
  endtask

  task automatic wait_scan_done(input int maxc);
    logic seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (scan_done) seen = 1'b1;
    end
    check("wait_scan_done", 32'(seen), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset, checked before any clock edge.
    #2 n_rst = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outputs", 32'({xfer_start, res_valid, scan_done, timeout_err}), 32'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;

    // Corner cases: empty mask, stray done in IDLE.
    chan_mask = '0;
    pulse_start();
    check("empty_mask_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("empty_mask_busy2", 32'(busy), 32'd0);
    @(posedge clk); #1 force_done = 1'b1;
    @(posedge clk); #1 force_done = 1'b0;
    check("idle_done_no_valid", 32'(res_valid), 32'd0);

    // Single scan of channels 2,5,7.
    engine_on = 1'b1;
    chan_mask = 8'hA4;
    exp_sel.push_back(5'd2); exp_sel.push_back(5'd5); exp_sel.push_back(5'd7);
    exp_res.push_back({5'd2, 12'h0A7});
    exp_res.push_back({5'd5, 12'h0AA});
    exp_res.push_back({5'd7, 12'h0AC});
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("lat_cycle1_busy", 32'(busy), 32'd1);
    check("lat_cycle1_no_xfer", 32'(xfer_start), 32'd0);
    @(posedge clk); #1;
    check("lat_cycle2_xfer", 32'(xfer_start), 32'd1);
    chan_mask = 8'hFF;          // must not alter the running scan
    start = 1'b1;               // must be ignored mid-scan
    @(posedge clk); #1 start = 1'b0;
    wait_scan_done(200);
    check("last_valid_with_done", 32'(res_valid), 32'd1);
    @(posedge clk); #1;
    check("single_busy_end", 32'(busy), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("res_hold", 32'({res_chan, res_data}), 32'({5'd7, 12'h0AC}));
    check("single_done_cnt", 32'(done_cnt), 32'd1);

    // Continuous scans of channels 0,1 with a 3-cycle gap.
    chan_mask = 8'h03;
    scan_gap = 16'd3;
    exp_sel.push_back(5'd0); exp_sel.push_back(5'd1);
    exp_res.push_back({5'd0, 12'h0A5}); exp_res.push_back({5'd1, 12'h0A6});
    @(posedge clk); #1 scan_en = 1'b1;
    wait_scan_done(200);
    check("cont_valid_with_done", 32'(res_valid), 32'd1);
    s0 = cyc;
    exp_sel.push_back(5'd0); exp_sel.push_back(5'd1);
    exp_res.push_back({5'd0, 12'h0A5}); exp_res.push_back({5'd1, 12'h0A6});
    wait_xfer_start(20);
    check("gap_done_to_xfer", 32'(cyc - s0), 32'd5);
    @(posedge clk); #1 scan_en = 1'b0;
    wait_scan_done(200);
    @(posedge clk); #1;
    check("cont_busy_end", 32'(busy), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("cont_done_cnt", 32'(done_cnt), 32'd3);

    // Timeout on channel 0 with the engine silent.
    engine_on = 1'b0;
    chan_mask = 8'h01;
    exp_sel.push_back(5'd0);
    pulse_start();
    wait_xfer_start(10);
    repeat (TO) @(negedge clk);
    check("err_before_timeout", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    check("timeout_scan_done", 32'(scan_done), 32'd1);
    @(posedge clk); #1;
    check("timeout_busy_end", 32'(busy), 32'd0);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    check("err_clr_clears", 32'(timeout_err), 32'd0);

    // err_clr held through a timeout: the timeout wins.
    exp_sel.push_back(5'd0);
    err_clr = 1'b1;
    pulse_start();
    wait_xfer_start(10);
    repeat (TO) @(negedge clk);
    check("simul_before", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("simul_err_set", 32'(timeout_err), 32'd1);
    err_clr = 1'b0;
    @(posedge clk); #1;
    check("simul_err_sticky", 32'(timeout_err), 32'd1);

    // Asynchronous reset in WAIT.
    exp_sel.push_back(5'd0);
    pulse_start();
    wait_xfer_start(10);
    @(posedge clk); #2;
    check("pre_reset_busy", 32'(busy), 32'd1);
    n_rst = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_flags", 32'({xfer_start, res_valid, scan_done, timeout_err}), 32'd0);
    check("async_rst_res", 32'({res_chan, res_data}), 32'd0);
    check("async_rst_chansel", 32'(xfer_chansel), 32'd0);
    @(negedge clk) n_rst = 1'b1;
    engine_on = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_idle", 32'(busy), 32'd0);

    check("sel_queue_empty", 32'(exp_sel.size()), 32'd0);
    check("res_queue_empty", 32'(exp_res.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
